// File: rtl/key_event_gen.sv
// -----------------------------------------------------------------------------
// key_event_gen
//
// Turns the debounced key level from a key filter into discrete key events:
// press, release, short press, long press and (optionally) auto-repeat while
// the key stays long-held. It also provides a held level and a press counter.
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   defined   -> repeat_pulse fires every REPEAT_CYC cycles while long-held
//   undefined -> no repeat counter is built and repeat_pulse is tied to 0
//
// Parameters
//   LONG_PRESS_CYC : hold cycles before a press counts as long (>= 2)
//   REPEAT_CYC     : auto-repeat period in cycles (>= 2)
//
// Ports
//   sys_clk       in   system clock
//   sys_rst_n     in   asynchronous reset, active-low
//   key_flag      in   one-cycle strobe, key_value has been updated
//   key_value     in   debounced key level (0 = pressed, 1 = released)
//   press_pulse   out  one-cycle strobe per accepted press
//   release_pulse out  one-cycle strobe per accepted release
//   short_pulse   out  one-cycle strobe on release before the long threshold
//   long_pulse    out  one-cycle strobe when the long threshold is reached
//   repeat_pulse  out  one-cycle strobe per repeat period while long-held
//   key_held      out  high while the key is pressed
//   press_cnt     out  accepted press count, modulo 256
// -----------------------------------------------------------------------------
module key_event_gen #(
  parameter int unsigned LONG_PRESS_CYC = 25000000,
  parameter int unsigned REPEAT_CYC     = 5000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_flag,
  input  logic       key_value,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       key_held,
  output logic [7:0] press_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] LONG    = 2'd2;

  localparam logic [31:0] HOLD_LAST = 32'(LONG_PRESS_CYC - 1);

  logic [1:0]  state;
  logic [31:0] hold_cnt;
  logic        press_ev;
  logic        release_ev;
  logic        hold_done;

  // key_value only means something in a key_flag cycle
  assign press_ev   = key_flag & ~key_value;
  assign release_ev = key_flag &  key_value;
  assign hold_done  = (hold_cnt == HOLD_LAST);

  // Main event state machine. A release wins over the long threshold when
  // both land in the same cycle, so that press is reported as short.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      hold_cnt      <= 32'd0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      key_held      <= 1'b0;
      press_cnt     <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= 32'd0;
          if (press_ev) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            key_held    <= 1'b1;
            press_cnt   <= press_cnt + 8'd1;
          end
        end
        PRESSED: begin
          if (release_ev) begin
            state         <= IDLE;
            hold_cnt      <= 32'd0;
            short_pulse   <= 1'b1;
            release_pulse <= 1'b1;
            key_held      <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
            if (hold_done) begin
              state      <= LONG;
              long_pulse <= 1'b1;
            end
          end
        end
        LONG: begin
          if (release_ev) begin
            state         <= IDLE;
            hold_cnt      <= 32'd0;
            release_pulse <= 1'b1;
            key_held      <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= 32'd0;
          key_held <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [31:0] REP_LAST = 32'(REPEAT_CYC - 1);

  logic [31:0] rep_cnt;

  // rep_cnt only runs while long-held; it sits at 0 everywhere else, which
  // makes it start from 0 on LONG entry. The release cycle leaves LONG, so
  // no repeat is issued together with the release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rep_cnt      <= 32'd0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (state == LONG && !release_ev) begin
        if (rep_cnt == REP_LAST) begin
          rep_cnt      <= 32'd0;
          repeat_pulse <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 32'd1;
        end
      end else begin
        rep_cnt <= 32'd0;
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_gen.sv
// -----------------------------------------------------------------------------
// tb_key_event_gen
//
// Self-checking bench for key_event_gen with LONG_PRESS_CYC=10, REPEAT_CYC=4.
// The reference model works on event times: it remembers the cycle a press
// was accepted and derives short/long/repeat from elapsed-cycle arithmetic.
// Repeat expectations follow KEY_AUTOREPEAT_EN, so the bench fits both builds.
// -----------------------------------------------------------------------------
module tb_key_event_gen;

  localparam int LONG = 10;
  localparam int REP  = 4;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_flag;
  logic       key_value;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       key_held;
  logic [7:0] press_cnt;

  key_event_gen #(
    .LONG_PRESS_CYC(LONG),
    .REPEAT_CYC    (REP)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_flag     (key_flag),
    .key_value    (key_value),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .key_held     (key_held),
    .press_cnt    (press_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         cyc = 0;
  bit         m_held = 0;
  int         m_press_t = 0;
  logic [7:0] m_cnt = 8'd0;

  // {press, release, short, long, repeat, held, cnt[7:0]}
  logic [13:0] act;
  logic [13:0] exp_v;

  function automatic bit autorepeat_on();
`ifdef KEY_AUTOREPEAT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock of stimulus plus the model's prediction for the following cycle.
  task automatic step(input logic flag, input logic val);
    bit e_press, e_rel, e_short, e_long, e_rep;
    e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_rep = 0;
    @(negedge sys_clk);
    key_flag  = flag;
    key_value = val;
    if (!sys_rst_n) begin
      m_held = 0;
      m_cnt  = 8'd0;
    end else if (flag && !val && !m_held) begin
      e_press   = 1;
      m_held    = 1;
      m_press_t = cyc;
      m_cnt     = m_cnt + 8'd1;
    end else if (flag && val && m_held) begin
      e_rel   = 1;
      e_short = (cyc <= m_press_t + LONG);
      m_held  = 0;
    end else if (m_held) begin
      if (cyc == m_press_t + LONG) e_long = 1;
      if (autorepeat_on() && cyc > m_press_t + LONG &&
          ((cyc - m_press_t - LONG) % REP) == 0) e_rep = 1;
    end
    exp_v = {e_press, e_rel, e_short, e_long, e_rep, m_held, m_cnt};
    @(posedge sys_clk);
    #1;
    act = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse,
           key_held, press_cnt};
    key_flag = 1'b0;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    key_flag  = 1'b0;
    key_value = 1'b1;
    #1;
    act = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse,
           key_held, press_cnt};
    n_cmp++;
    if (act !== 14'd0) begin
      n_err++;
      $display("[TB] FAIL reset_async got=%h exp=%h", act, 14'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (act !== 14'd0) begin
        n_err++;
        $display("[TB] FAIL reset_held cyc=%0d got=%h exp=%h", cyc, act, 14'd0);
      end
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_steps(2);
  endtask

  task automatic test_short_press();
    int         press_at, short_at, long_seen;
    logic [7:0] cnt0;
    press_at = -1; short_at = -1; long_seen = 0;
    cnt0 = m_cnt;
    for (int i = 0; i <= 8; i++) begin
      if (i == 0)      step(1'b1, 1'b0);
      else if (i == 5) step(1'b1, 1'b1);
      else             step(1'b0, 1'b1);
      if (act[13]) press_at = i + 1;
      if (act[11] && act[12]) short_at = i + 1;
      if (act[10]) long_seen++;
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("[TB] FAIL short_press cyc=%0d got=%h exp=%h", cyc, act, exp_v);
      end
    end
    n_cmp++;
    if (press_at !== 1 || short_at !== 6 || long_seen !== 0 || press_cnt !== cnt0 + 8'd1) begin
      n_err++;
      $display("[TB] FAIL short_timing got press=%0d short=%0d long=%0d cnt=%0d exp press=1 short=6 long=0 cnt=%0d",
               press_at, short_at, long_seen, press_cnt, cnt0 + 8'd1);
    end
  endtask

  task automatic test_long_press();
    int n_long, n_rep, n_short, n_rel, long_at;
    n_long = 0; n_rep = 0; n_short = 0; n_rel = 0; long_at = -1;
    for (int i = 0; i <= 33; i++) begin
      if (i == 0)       step(1'b1, 1'b0);
      else if (i == 31) step(1'b1, 1'b1);
      else              step(1'b0, 1'b1);
      if (act[10]) begin n_long++; long_at = i + 1; end
      if (act[9])  n_rep++;
      if (act[11]) n_short++;
      if (act[12]) n_rel++;
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("[TB] FAIL long_press cyc=%0d got=%h exp=%h", cyc, act, exp_v);
      end
    end
    n_cmp++;
    if (n_long !== 1 || long_at !== 11 || n_short !== 0 || n_rel !== 1 ||
        n_rep !== (autorepeat_on() ? 5 : 0)) begin
      n_err++;
      $display("[TB] FAIL long_counts got long=%0d@%0d rep=%0d short=%0d rel=%0d exp long=1@11 rep=%0d short=0 rel=1",
               n_long, long_at, n_rep, n_short, n_rel, autorepeat_on() ? 5 : 0);
    end
  endtask

  task automatic test_boundary();
    int n_long, n_short;
    n_long = 0; n_short = 0;
    for (int i = 0; i <= 12; i++) begin
      if (i == 0)       step(1'b1, 1'b0);
      else if (i == 10) step(1'b1, 1'b1);
      else              step(1'b0, 1'b1);
      if (act[10]) n_long++;
      if (act[11]) n_short++;
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("[TB] FAIL boundary cyc=%0d got=%h exp=%h", cyc, act, exp_v);
      end
    end
    n_cmp++;
    if (n_long !== 0 || n_short !== 1) begin
      n_err++;
      $display("[TB] FAIL boundary_short got long=%0d short=%0d exp long=0 short=1",
               n_long, n_short);
    end
  endtask

  task automatic test_redundant();
    logic [7:0] cnt0;
    int         n_pulse;
    cnt0 = press_cnt;
    n_pulse = 0;
    for (int i = 0; i <= 8; i++) begin
      case (i)
        0, 1: step(1'b1, 1'b1);
        2:    step(1'b1, 1'b0);
        4, 5: step(1'b1, 1'b0);
        6:    step(1'b1, 1'b1);
        7:    step(1'b1, 1'b1);
        default: step(1'b0, 1'b1);
      endcase
      n_pulse += act[13] + act[12] + act[11] + act[10] + act[9];
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("[TB] FAIL redundant cyc=%0d got=%h exp=%h", cyc, act, exp_v);
      end
    end
    n_cmp++;
    if (press_cnt !== cnt0 + 8'd1 || n_pulse !== 3) begin
      n_err++;
      $display("[TB] FAIL redundant_totals got cnt=%0d pulses=%0d exp cnt=%0d pulses=3",
               press_cnt, n_pulse, cnt0 + 8'd1);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] cnt0;
    cnt0 = press_cnt;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 5; i++) begin
        if (i == 0)      step(1'b1, 1'b0);
        else if (i == 2) step(1'b1, 1'b1);
        else             step(1'b0, 1'b1);
        n_cmp++;
        if (act !== exp_v) begin
          n_err++;
          $display("[TB] FAIL wrap cyc=%0d got=%h exp=%h", cyc, act, exp_v);
        end
      end
    end
    n_cmp++;
    if (press_cnt !== cnt0) begin
      n_err++;
      $display("[TB] FAIL wrap_count got=%0d exp=%0d", press_cnt, cnt0);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0);
    idle_steps(14);
    n_cmp++;
    if (key_held !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL pre_reset_held got=%b exp=1", key_held);
    end
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    m_held = 0;
    m_cnt  = 8'd0;
    #1;
    act = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse,
           key_held, press_cnt};
    n_cmp++;
    if (act !== 14'd0) begin
      n_err++;
      $display("[TB] FAIL reset_mid_async got=%h exp=%h", act, 14'd0);
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 3) step(1'b1, 1'b1);
      else if (i == 6)      step(1'b1, 1'b0);
      else                  step(1'b0, 1'b1);
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("[TB] FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, act, exp_v);
      end
    end
    n_cmp++;
    if (press_cnt !== 8'd1 || key_held !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_mid_press got cnt=%0d held=%b exp cnt=1 held=1",
               press_cnt, key_held);
    end
    step(1'b1, 1'b1);
    idle_steps(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) step(1'b1, 1'($urandom_range(0, 1)));
      else                           step(1'b0, 1'($urandom_range(0, 1)));
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, act, exp_v);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_short_press();
    idle_steps(2);
    test_long_press();
    idle_steps(2);
    test_boundary();
    idle_steps(2);
    test_redundant();
    idle_steps(2);
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_event_gen.md
KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 SHALL provide parameter LONG_PRESS_CYC, default 25000000, giving the hold cycles (500 ms at 50 MHz) before a press counts as long.
REQ-002 SHALL provide parameter REPEAT_CYC, default 5000000, giving the auto-repeat period in cycles (100 ms at 50 MHz).
REQ-003 SHALL have port sys_clk  input  1  system clock (50 MHz).
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port key_flag  input  1  one-cycle strobe: debounced key state updated.
REQ-006 SHALL have port key_value  input  1  debounced key level, valid with key_flag; 0 = pressed, 1 = released.
REQ-007 SHALL have port press_pulse  output  1  one-cycle strobe on each accepted press.
REQ-008 SHALL have port release_pulse  output  1  one-cycle strobe on each accepted release.
REQ-009 SHALL have port short_pulse  output  1  one-cycle strobe on a release before the long threshold.
REQ-010 SHALL have port long_pulse  output  1  one-cycle strobe when the long threshold is reached.
REQ-011 SHALL have port repeat_pulse  output  1  one-cycle strobe per repeat period while long-held.
REQ-012 SHALL have port key_held  output  1  level, high while the key is pressed.
REQ-013 SHALL have port press_cnt  output  8  count of accepted presses, modulo 256.

Function
REQ-014 SHALL sample key_value only in cycles where key_flag=1; key_value is ignored otherwise.
REQ-015 SHALL implement states IDLE, PRESSED and LONG, all encoded in one registered state machine.
REQ-016 SHALL, in IDLE on key_flag=1 with key_value=0, go to PRESSED, clear hold_cnt, and assert press_pulse in the next cycle (1-cycle latency from key_flag).
REQ-017 SHALL ignore key_flag events that repeat the current level: press while PRESSED/LONG, release while IDLE.
REQ-018 SHALL, in PRESSED, increment a 32-bit hold_cnt every cycle; when hold_cnt equals LONG_PRESS_CYC-1, go to LONG and assert long_pulse for one cycle.
REQ-019 SHALL, in PRESSED on release, go to IDLE and assert short_pulse and release_pulse in the same cycle.
REQ-020 SHALL, in LONG on release, go to IDLE and assert release_pulse only, never short_pulse.
REQ-021 SHALL treat a release in the same cycle hold_cnt reaches LONG_PRESS_CYC-1 as short: short_pulse and release_pulse asserted, long_pulse suppressed.
REQ-022 SHALL drive key_held high in PRESSED and LONG and low in IDLE, registered, aligned with press_pulse/release_pulse.
REQ-023 SHALL increment press_cnt by 1 in the same cycle as press_pulse, wrapping 255 -> 0.
REQ-024 SHALL produce all pulse outputs from registers, each high for exactly one cycle per event.
REQ-025 SHALL hold hold_cnt and rep_cnt at 0 in IDLE so that neither counter can overflow.
REQ-026 SHALL require LONG_PRESS_CYC >= 2 and REPEAT_CYC >= 2; behaviour for smaller values is undefined.

Reset
REQ-027 SHALL, while sys_rst_n=0, force state IDLE, hold_cnt=0, rep_cnt=0, press_cnt=0, and all pulses and key_held to 0.
REQ-028 SHALL, when reset is asserted mid-press, emit no release_pulse or short_pulse; the next accepted event after reset is a press only.

Configuration
REQ-029 SHALL, with macro KEY_AUTOREPEAT_EN defined, count rep_cnt in LONG starting at 0 on entry and assert repeat_pulse each time rep_cnt reaches REPEAT_CYC-1 (first repeat REPEAT_CYC cycles after long_pulse), then reload rep_cnt to 0.
REQ-030 SHALL, with macro KEY_AUTOREPEAT_EN defined, suppress repeat_pulse in the cycle a release is accepted.
REQ-031 SHALL, without KEY_AUTOREPEAT_EN, omit rep_cnt logic, hold repeat_pulse constant 0, and have LONG simply wait for release.

Verification (LONG_PRESS_CYC=10, REPEAT_CYC=4)
REQ-032 SHALL cover a short press: press flag at cycle 0, release flag at cycle 5 -> press_pulse at cycle 1, short_pulse and release_pulse at cycle 6, no long_pulse, press_cnt=1.
REQ-033 SHALL cover a long press with KEY_AUTOREPEAT_EN: press at cycle 0, hold 30 cycles -> long_pulse once, repeat_pulse every 4 cycles after it, release_pulse on release, no short_pulse.
REQ-034 SHALL cover the boundary case: release flag in the same cycle hold_cnt=9 -> short_pulse=1, long_pulse=0.
REQ-035 SHALL cover redundant events: press flag while PRESSED and release flag while IDLE -> no pulses, press_cnt unchanged.
REQ-036 SHALL cover wrap-around: 256 short presses -> press_cnt returns to 0.
REQ-037 SHALL cover reset mid-operation: sys_rst_n low while in LONG -> all outputs 0 and IDLE immediately; no pulses after release of reset until a new press flag.
